// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared widths and the fixed zero-register address used by the
//               register file and its read ports.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO_ADDR = 5'd0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/banco_registros_32_puerto_lectura.sv
`default_nettype none
// ============================================================================
// Module      : puerto_lectura
// Description : One registered read port of the register file. It applies the
//               zero-register check, the write->read bypass, and holds the
//               output while the read enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module puerto_lectura
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              is_zero;
  logic              bypass_hit;

  // Zero check has priority over the bypass so a write to entry 0 never leaks out.
  always_comb begin
    is_zero    = (ZERO_REG != 0) && (raddr == ZERO_ADDR);
    bypass_hit = we && (waddr == raddr);
    rdata_d    = rdata_q;
    if (re) begin
      if (is_zero) begin
        rdata_d = '0;
      end else if (bypass_hit) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_rdata;
      end
    end
  end

  // Output register: synchronous clear, otherwise load the next read value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : puerto_lectura
`default_nettype wire

// File: rtl/banco_registros_32.sv
`default_nettype none
// ============================================================================
// Module      : banco_registros_32
// Description : 32 x 32-bit CPU register file. One write port (write-back)
//               and two independent registered read ports (decode operands)
//               with same-cycle write->read bypass. Entry 0 optionally
//               hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registros_32
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

  logic [DEPTH-1:0][DATA_W-1:0] mem_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic                         write_ok;

  // Next storage contents: a write to entry 0 is dropped when it is hardwired.
  always_comb begin
    write_ok = we && !((ZERO_REG != 0) && (waddr == ZERO_ADDR));
    mem_d    = mem_q;
    if (write_ok) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage array: reset clears every entry and overrides any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  puerto_lectura #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_puerto_a (
    .clk       (clk),
    .reset     (reset),
    .re        (re_a),
    .raddr     (raddr_a),
    .mem_rdata (mem_q[raddr_a]),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata     (rdata_a)
  );

  puerto_lectura #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_puerto_b (
    .clk       (clk),
    .reset     (reset),
    .re        (re_b),
    .raddr     (raddr_b),
    .mem_rdata (mem_q[raddr_b]),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata     (rdata_b)
  );

endmodule : banco_registros_32
`default_nettype wire

// File: tb/tb_banco_registros_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registros_32
// Description : Self-checking bench for banco_registros_32. Each driven cycle
//               pushes the expected read-port values to a scoreboard queue;
//               they are popped and compared one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_registros_32;

  typedef struct {
    string       tag;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re_a;
  logic [4:0]  raddr_a;
  logic [31:0] rdata_a;
  logic        re_b;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_b;

  int          n_checks;
  int          n_fail;
  sb_entry_t   sb_q[$];
  logic [31:0] model_mem[32];
  logic [31:0] model_a;
  logic [31:0] model_b;

  banco_registros_32 dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re_a    (re_a),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .re_b    (re_b),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expected_read(input logic [4:0] ra, input logic w,
                                                input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'h0;
    if (w && (wa == ra)) return wd;
    return model_mem[ra];
  endfunction

  // One clock cycle: drive inputs at negedge, predict, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ra_en, input logic [4:0] ra,
                      input logic rb_en, input logic [4:0] rb);
    sb_entry_t e;
    sb_entry_t got_e;
    @(negedge clk);
    reset = rst; we = w; waddr = wa; wdata = wd;
    re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb;
    if (rst) begin
      model_a = 32'h0;
      model_b = 32'h0;
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    end else begin
      if (ra_en) model_a = expected_read(ra, w, wa, wd);
      if (rb_en) model_b = expected_read(rb, w, wa, wd);
      if (w && (wa != 5'd0)) model_mem[wa] = wd;
    end
    e.tag = tag; e.exp_a = model_a; e.exp_b = model_b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      got_e = sb_q.pop_front();
      check({got_e.tag, "_a"}, rdata_a, got_e.exp_a);
      check({got_e.tag, "_b"}, rdata_b, got_e.exp_b);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_a  = 32'h0;
    model_b  = 32'h0;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;

    // Reset state
    step("rst_init", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rst_init2", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);

    // 1: fill with ones, reset, read everything back as zero
    for (int i = 0; i < 32; i++)
      step("fill", 1'b0, 1'b1, 5'(i), 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd0);
    step("fill_rd", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd31);
    step("rst_pulse", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd31);
    for (int i = 0; i < 32; i++)
      step("rst_clear", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));

    // 2: write then read
    step("wr_r5", 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rd_r5", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);

    // 3: same-cycle bypass
    step("bypass_r7", 1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 1'b1, 5'd7);
    step("bypass_a", 1'b0, 1'b1, 5'd8, 32'hCAFE_0008, 1'b1, 5'd8, 1'b1, 5'd7);

    // 4: zero register, plain and bypassed
    step("wr_r0", 1'b0, 1'b1, 5'd0, 32'hAAAA_AAAA, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rd_r0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    step("rd_r0_prime", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);
    step("bypass_r0", 1'b0, 1'b1, 5'd0, 32'hAAAA_AAAA, 1'b1, 5'd0, 1'b1, 5'd0);

    // 5: dual read, stall while r3 is rewritten, then re-read
    step("wr_r3", 1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
    step("wr_r9", 1'b0, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rd_3_9", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd9);
    step("stall1", 1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 1'b0, 5'd9);
    step("stall2", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'd9);
    step("stall3", 1'b0, 1'b1, 5'd9, 32'h44, 1'b0, 5'd3, 1'b0, 5'd9);
    step("rd_new_r3", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd9);

    // 6: reset wins over a simultaneous write
    step("rst_vs_wr", 1'b1, 1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 1'b1, 5'd4);
    step("rd_r4", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4);
    // First cycle after reset: bypass on one port, stale-zero on the other
    step("rst_rel", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    step("post_rst_byp", 1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 1'b1, 5'd5);

    // Random mixed traffic
    for (int i = 0; i < 200; i++)
      step("rand", 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_banco_registros_32
`default_nettype wire
